// File: rtl/word_assembler_if.sv
// Byte-stream-in / word-out bundle for word_assembler.
// The assembler sits on the slave side; the producer/observer uses master.
interface word_assembler_if #(
    parameter int WIDTH = 32,
    parameter int BYTE  = 8
);
    logic             in_valid;
    logic [BYTE-1:0]  in_data;
    logic             in_ready;
    logic             clr;
    logic             ld;
    logic [WIDTH-1:0] out;
    logic             busy;

    modport master (
        output in_valid,
        output in_data,
        output clr,
        input  in_ready,
        input  ld,
        input  out,
        input  busy
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  clr,
        output in_ready,
        output ld,
        output out,
        output busy
    );
endinterface

// File: rtl/word_assembler.sv
// Packs WIDTH/BYTE little-endian beats into one word and pulses ld for a
// single cycle with the completed word on out; every output is registered.
module word_assembler #(
    parameter int WIDTH = 32,
    parameter int BYTE  = 8
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    word_assembler_if.slave bus
);
    localparam int N  = WIDTH / BYTE;
    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        S_INIT    = 2'd0,
        S_COLLECT = 2'd1,
        S_EMIT    = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [WIDTH-1:0] out_q, out_d;
    logic             ld_q, ld_d;
    logic             in_ready_q, in_ready_d;
    logic             busy_q, busy_d;
    logic             accept_s;
    logic             last_s;
    logic [WIDTH-1:0] word_s;

    function automatic logic [WIDTH-1:0] insert_beat(
        input logic [WIDTH-1:0] word,
        input logic [CW-1:0]    idx,
        input logic [BYTE-1:0]  beat
    );
        logic [WIDTH-1:0] r;
        r = word;
        for (int k = 0; k < N; k++) begin
            if (idx == CW'(k)) begin
                r[k*BYTE +: BYTE] = beat;
            end else begin
                r[k*BYTE +: BYTE] = r[k*BYTE +: BYTE];
            end
        end
        return r;
    endfunction

    // in_ready_q is high only in COLLECT, so it doubles as the accept qualifier
    assign accept_s = bus.in_valid & in_ready_q;
    assign last_s   = (count_q == CW'(N - 1));
    assign word_s   = insert_beat(shadow_q, count_q, bus.in_data);

    // Next-state logic; clr beats a simultaneous accept and is ignored outside COLLECT
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        shadow_d   = shadow_q;
        out_d      = out_q;
        ld_d       = 1'b0;
        in_ready_d = in_ready_q;
        case (state_q)
            S_INIT: begin
                state_d    = S_COLLECT;
                in_ready_d = 1'b1;
            end
            S_COLLECT: begin
                in_ready_d = 1'b1;
                if (bus.clr) begin
                    count_d  = '0;
                    shadow_d = '0;
                end else if (accept_s) begin
                    if (last_s) begin
                        count_d    = '0;
                        shadow_d   = '0;
                        out_d      = word_s;
                        state_d    = S_EMIT;
                        ld_d       = 1'b1;
                        in_ready_d = 1'b0;
                    end else begin
                        count_d  = count_q + CW'(1);
                        shadow_d = word_s;
                    end
                end else begin
                    count_d = count_q;
                end
            end
            S_EMIT: begin
                state_d    = S_COLLECT;
                in_ready_d = 1'b1;
            end
            default: begin
                state_d    = S_INIT;
                count_d    = '0;
                shadow_d   = '0;
                in_ready_d = 1'b0;
            end
        endcase
        busy_d = (count_d != '0) || (state_d == S_EMIT);
    end

    // State and output registers
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_INIT;
            count_q    <= '0;
            shadow_q   <= '0;
            out_q      <= '0;
            ld_q       <= 1'b0;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            shadow_q   <= shadow_d;
            out_q      <= out_d;
            ld_q       <= ld_d;
            in_ready_q <= in_ready_d;
            busy_q     <= busy_d;
        end
    end

    assign bus.in_ready = in_ready_q;
    assign bus.ld       = ld_q;
    assign bus.out      = out_q;
    assign bus.busy     = busy_q;
endmodule
